// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive blocks: FSM state
// encoding, bit-order constants and the default word width.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic DIR_MSB_FIRST = 1'b1;
  localparam logic DIR_LSB_FIRST = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : serial_pkg

// File: rtl/piso_serializer_if.sv
// Word-input handshake plus serial-output bundle of the PISO transmitter.
// master = word producer / serial consumer, slave = the serializer.
interface piso_serializer_if #(
   parameter int WIDTH = serial_pkg::DEFAULT_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_dir;
   logic             serial_out;
   logic             serial_valid;
   logic             frame_start;
   logic             frame_last;
   logic             busy;

   modport master (
      output in_valid, in_data, in_dir,
      input  in_ready, serial_out, serial_valid, frame_start, frame_last, busy
   );

   modport slave (
      input  in_valid, in_data, in_dir,
      output in_ready, serial_out, serial_valid, frame_start, frame_last, busy
   );

endinterface : piso_serializer_if

// File: rtl/piso_hold_buf.sv
// One-entry holding register (word + bit order) that lets the next word be
// accepted while the current frame is still shifting.
module piso_hold_buf #(
   parameter int WIDTH = serial_pkg::DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_dir,
   input  logic             rd_en,
   output logic [WIDTH-1:0] data,
   output logic             dir,
   output logic             full
);

   // NOTE: sequential state uses <= so every flop samples pre-edge values
   // regardless of the order the simulator evaluates processes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full <= 1'b0;
      end else if (wr_en) begin
         full <= 1'b1;
      end else if (rd_en) begin
         full <= 1'b0;
      end
   end

   // NOTE: payload flops are not reset; full qualifies them, so a reset value
   // would only add reset fan-out without changing behaviour.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data <= wr_data;
         dir  <= wr_dir;
      end
   end

endmodule : piso_hold_buf

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word input, one bit per
// clock out, per-word MSB/LSB order, gapless back-to-back frames via a hold buffer.
module piso_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic              clk,
   input logic              rst_n,
   piso_serializer_if.slave bus
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e             state;
   state_e             state_nxt;
   logic [WIDTH-1:0]   sreg;
   logic               cur_dir;
   logic [CNT_W-1:0]   bit_cnt;

   logic               hold_full;
   logic [WIDTH-1:0]   hold_data;
   logic               hold_dir;
   logic               hold_wr;
   logic               hold_rd;

   logic               transfer;
   logic               last_bit;
   logic               load_in;
   logic               load_hold;
   logic               shift_en;

   // in_ready is the inverse of a flop, so no input reaches any output combinationally.
   assign bus.in_ready = !hold_full;
   assign transfer     = bus.in_valid && !hold_full;
   assign last_bit     = (state == ST_SHIFT) && (bit_cnt == LAST_CNT);

   piso_hold_buf #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (hold_wr),
      .wr_data (bus.in_data),
      .wr_dir  (bus.in_dir),
      .rd_en   (hold_rd),
      .data    (hold_data),
      .dir     (hold_dir),
      .full    (hold_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path
      // through the case leaves one unassigned and infers a latch.
      state_nxt = state;
      load_in   = 1'b0;
      load_hold = 1'b0;
      shift_en  = 1'b0;
      hold_wr   = 1'b0;
      hold_rd   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (transfer) begin
               load_in   = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last_bit) begin
               // A waiting hold word has priority; in_ready is low then anyway.
               if (hold_full) begin
                  load_hold = 1'b1;
                  hold_rd   = 1'b1;
               end else if (transfer) begin
                  load_in = 1'b1;
               end else begin
                  shift_en  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end else begin
               shift_en = 1'b1;
               hold_wr  = transfer;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sreg    <= '0;
         cur_dir <= DIR_LSB_FIRST;
         bit_cnt <= '0;
      end else if (load_in) begin
         sreg    <= bus.in_data;
         cur_dir <= bus.in_dir;
         bit_cnt <= '0;
      end else if (load_hold) begin
         sreg    <= hold_data;
         cur_dir <= hold_dir;
         bit_cnt <= '0;
      end else if (shift_en) begin
         // The final shift of a frame leaves sreg all-zero, so an idle line reads 0.
         sreg    <= (cur_dir == DIR_MSB_FIRST) ? {sreg[WIDTH-2:0], 1'b0}
                                               : {1'b0, sreg[WIDTH-1:1]};
         bit_cnt <= (bit_cnt == LAST_CNT) ? '0 : bit_cnt + 1'b1;
      end
   end

   assign bus.serial_out   = (cur_dir == DIR_MSB_FIRST) ? sreg[WIDTH-1] : sreg[0];
   assign bus.serial_valid = (state == ST_SHIFT);
   assign bus.frame_start  = (state == ST_SHIFT) && (bit_cnt == '0);
   assign bus.frame_last   = last_bit;
   assign bus.busy         = (state == ST_SHIFT) || hold_full;

   hold_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
      !(hold_wr && hold_full));
   hold_no_rw_clash: assert property (@(posedge clk) disable iff (!rst_n)
      !(hold_wr && hold_rd));

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a vector table for single frames and
// the last-cycle direct load, hand-written sequences for hold and mid-frame reset.
module tb_piso_serializer;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   piso_serializer_if #(.WIDTH(4)) bus ();

   piso_serializer #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected outputs packed as {in_ready, serial_out, serial_valid, frame_start, frame_last, busy}.
   typedef struct {
      logic       valid;
      logic [3:0] data;
      logic       dir;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[19];

   function automatic vec_t mk(logic v, logic [3:0] d, logic dr, logic [5:0] e);
      vec_t r;
      r.valid = v;
      r.data  = d;
      r.dir   = dr;
      r.exp   = e;
      return r;
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [5:0] e);
      check({tag, " in_ready"},     bus.in_ready,     e[5]);
      check({tag, " serial_out"},   bus.serial_out,   e[4]);
      check({tag, " serial_valid"}, bus.serial_valid, e[3]);
      check({tag, " frame_start"},  bus.frame_start,  e[2]);
      check({tag, " frame_last"},   bus.frame_last,   e[1]);
      check({tag, " busy"},         bus.busy,         e[0]);
   endtask

   task automatic drive(input logic v, input logic [3:0] d, input logic dr);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_dir   = dr;
   endtask

   initial begin
      logic [7:0] bb_bits;
      logic [7:0] bb_rdy;
      logic [3:0] rs_bits;
      int         n;

      // MSB first 1011
      vecs[0]  = mk(1'b1, 4'hB, 1'b1, 6'b111101);
      vecs[1]  = mk(1'b0, 4'h0, 1'b0, 6'b101001);
      vecs[2]  = mk(1'b0, 4'h0, 1'b0, 6'b111001);
      vecs[3]  = mk(1'b0, 4'h0, 1'b0, 6'b111011);
      vecs[4]  = mk(1'b0, 4'h0, 1'b0, 6'b100000);
      // LSB first 1011
      vecs[5]  = mk(1'b1, 4'hB, 1'b0, 6'b111101);
      vecs[6]  = mk(1'b0, 4'h0, 1'b0, 6'b111001);
      vecs[7]  = mk(1'b0, 4'h0, 1'b0, 6'b101001);
      vecs[8]  = mk(1'b0, 4'h0, 1'b0, 6'b111011);
      vecs[9]  = mk(1'b0, 4'h0, 1'b0, 6'b100000);
      // 0110 MSB first, then 1100 offered exactly on its last bit
      vecs[10] = mk(1'b1, 4'h6, 1'b1, 6'b101101);
      vecs[11] = mk(1'b0, 4'h0, 1'b0, 6'b111001);
      vecs[12] = mk(1'b0, 4'h0, 1'b0, 6'b111001);
      vecs[13] = mk(1'b0, 4'h0, 1'b0, 6'b101011);
      vecs[14] = mk(1'b1, 4'hC, 1'b1, 6'b111101);
      vecs[15] = mk(1'b0, 4'h0, 1'b0, 6'b111001);
      vecs[16] = mk(1'b0, 4'h0, 1'b0, 6'b101001);
      vecs[17] = mk(1'b0, 4'h0, 1'b0, 6'b101011);
      vecs[18] = mk(1'b0, 4'h0, 1'b0, 6'b100000);

      // Reset held for two edges with a word offered the whole time.
      rst_n = 1'b0;
      drive(1'b1, 4'hF, 1'b1);
      @(negedge clk);
      expect_out("reset1", 6'b100000);
      @(negedge clk);
      expect_out("reset2", 6'b100000);
      rst_n = 1'b1;
      drive(1'b0, 4'h0, 1'b0);
      @(negedge clk);
      expect_out("post_reset", 6'b100000);

      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].valid, vecs[i].data, vecs[i].dir);
         @(negedge clk);
         expect_out($sformatf("row%0d", i), vecs[i].exp);
      end

      // Back-to-back: A (MSB first) then 5 (LSB first) waiting in hold.
      bb_bits = 8'b1010_1010;
      bb_rdy  = 8'b1000_1111;
      drive(1'b1, 4'hA, 1'b1);
      @(negedge clk);
      for (int c = 0; c < 8; c++) begin
         check($sformatf("bb%0d serial_valid", c), bus.serial_valid, 1'b1);
         check($sformatf("bb%0d serial_out", c),   bus.serial_out,   bb_bits[7-c]);
         check($sformatf("bb%0d in_ready", c),     bus.in_ready,     bb_rdy[7-c]);
         check($sformatf("bb%0d frame_start", c),  bus.frame_start,  (c == 0) || (c == 4));
         check($sformatf("bb%0d frame_last", c),   bus.frame_last,   (c == 3) || (c == 7));
         check($sformatf("bb%0d busy", c),         bus.busy,         1'b1);
         if (c == 0) drive(1'b1, 4'h5, 1'b0);
         else        drive(1'b0, 4'h0, 1'b0);
         @(negedge clk);
      end
      expect_out("bb_end", 6'b100000);

      // Reset after two bits of F with 9 held: both words are discarded.
      drive(1'b1, 4'hF, 1'b1);
      @(negedge clk);
      expect_out("rs_bit0", 6'b111101);
      drive(1'b1, 4'h9, 1'b0);
      @(negedge clk);
      expect_out("rs_bit1", 6'b011001);
      drive(1'b0, 4'h0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      expect_out("rs_abort", 6'b100000);
      rst_n = 1'b1;
      @(negedge clk);
      expect_out("rs_hold_lost", 6'b100000);

      drive(1'b1, 4'h3, 1'b1);
      @(negedge clk);
      drive(1'b0, 4'h0, 1'b0);
      n = 0;
      while (!bus.serial_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("rs_new_frame timeout", (n >= 8), 1'b0);
      check("rs_new_frame latency", (n == 0), 1'b1);
      rs_bits = 4'b0011;
      for (int c = 0; c < 4; c++) begin
         check($sformatf("rs_new%0d serial_valid", c), bus.serial_valid, 1'b1);
         check($sformatf("rs_new%0d serial_out", c),   bus.serial_out,   rs_bits[3-c]);
         check($sformatf("rs_new%0d frame_start", c),  bus.frame_start,  (c == 0));
         check($sformatf("rs_new%0d frame_last", c),   bus.frame_last,   (c == 3));
         @(negedge clk);
      end
      expect_out("rs_end", 6'b100000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_piso_serializer
